// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave register bank.
// State encoding, default geometry and synchroniser depth.
package spi_slave_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      FULL = 2'd2
   } spi_state_t;

   localparam int SPI_WIDTH_DEF   = 16;
   localparam int SPI_REGS_DEF    = 3;
   localparam int SPI_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_slave_bank_sync.sv
// Two-flop synchroniser followed by a registered rise/fall detector.
// q is the edge-flop level, so it lines up with the rise/fall pulses.
module spi_sync_edge
   import spi_slave_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [SPI_SYNC_STAGES-1:0] sync;
   logic                       prev;

   // Synchronise the pin, then compare the settled level with its last value
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync <= '0;
         prev <= 1'b0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         sync <= {sync[SPI_SYNC_STAGES-2:0], d};
         prev <= sync[SPI_SYNC_STAGES-1];
         rise <= sync[SPI_SYNC_STAGES-1] & ~prev;
         fall <= ~sync[SPI_SYNC_STAGES-1] & prev;
      end
   end

   assign q = prev;

endmodule

// File: rtl/spi_slave_bank.sv
// SPI mode-0 slave assembling NUM_REGS words of WIDTH bits into a bank.
// Define SPI_SLAVE_MISO_EN to add the master_miso readback path.
module spi_slave_bank
   import spi_slave_pkg::*;
#(
   parameter  int WIDTH     = SPI_WIDTH_DEF,
   parameter  int NUM_REGS  = SPI_REGS_DEF,
   parameter  int MSB_FIRST = 1,
   localparam int IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      master_clk,
   input  logic                      master_chip_select,
   input  logic                      master_data,
   output logic [NUM_REGS*WIDTH-1:0] data_in,
   output logic                      word_valid,
   output logic [IDX_W-1:0]          word_index,
   output logic                      frame_done,
   output logic                      partial_err,
   output logic                      overrun
`ifdef SPI_SLAVE_MISO_EN
   ,
   output logic                      master_miso
`endif
);

   localparam int BC_W = $clog2(WIDTH + 1);
   localparam int WC_W = $clog2(NUM_REGS + 1);

   logic sclk_rise, sclk_fall, sclk_lvl;
   logic cs_rise, cs_fall, cs_lvl;
   logic mosi, mosi_unused_rise, mosi_unused_fall;

   spi_sync_edge u_sclk (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (master_clk),
      .q     (sclk_lvl),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   spi_sync_edge u_cs (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (master_chip_select),
      .q     (cs_lvl),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   spi_sync_edge u_mosi (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (master_data),
      .q     (mosi),
      .rise  (mosi_unused_rise),
      .fall  (mosi_unused_fall)
   );

   logic mosi_unused_lvls;
   assign mosi_unused_lvls = sclk_lvl ^ cs_lvl;

   spi_state_t       state, state_nx;
   logic [WIDTH-1:0] sh, sh_nx;
   logic [BC_W-1:0]  bit_cnt;
   logic [WC_W-1:0]  word_cnt;

   logic start_frame, end_frame, take_bit, set_ovr;
   logic word_done, last_word;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next state: chip-select fall always wins over a same-cycle clock edge
   always_comb begin
      state_nx = state;
      if (start_frame)
         state_nx = RECV;
      else if (end_frame)
         state_nx = IDLE;
      else if (word_done && last_word)
         state_nx = FULL;
   end

   // Per-state event qualification driving the datapath
   always_comb begin
      start_frame = 1'b0;
      end_frame   = 1'b0;
      take_bit    = 1'b0;
      set_ovr     = 1'b0;
      unique case (state)
         IDLE: start_frame = cs_rise;
         RECV: begin
            end_frame = cs_fall;
            take_bit  = sclk_rise & ~cs_fall;
         end
         FULL: begin
            end_frame = cs_fall;
            set_ovr   = sclk_rise & ~cs_fall;
         end
         default: ;
      endcase
   end

   assign word_done = take_bit && (bit_cnt == BC_W'(WIDTH - 1));
   assign last_word = (word_cnt == WC_W'(NUM_REGS - 1));

   // Shift direction selects which end the first bit lands in
   always_comb begin
      sh_nx = sh;
      if (MSB_FIRST != 0) sh_nx = {sh[WIDTH-2:0], mosi};
      else                sh_nx = {mosi, sh[WIDTH-1:1]};
   end

   // Bit/word counting, bank writes and status pulses
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sh          <= '0;
         bit_cnt     <= '0;
         word_cnt    <= '0;
         data_in     <= '0;
         word_valid  <= 1'b0;
         word_index  <= '0;
         frame_done  <= 1'b0;
         partial_err <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         word_valid  <= 1'b0;
         frame_done  <= 1'b0;
         partial_err <= 1'b0;
         if (start_frame) begin
            bit_cnt  <= '0;
            word_cnt <= '0;
            overrun  <= 1'b0;
         end
         if (end_frame) begin
            frame_done  <= 1'b1;
            partial_err <= (bit_cnt != '0);
            bit_cnt     <= '0;
         end
         if (set_ovr) overrun <= 1'b1;
         if (take_bit) begin
            sh <= sh_nx;
            if (word_done) begin
               bit_cnt    <= '0;
               word_cnt   <= word_cnt + 1'b1;
               word_valid <= 1'b1;
               word_index <= IDX_W'(word_cnt);
               for (int k = 0; k < NUM_REGS; k++)
                  if (word_cnt == WC_W'(k))
                     data_in[k*WIDTH +: WIDTH] <= sh_nx;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end
      end
   end

`ifdef SPI_SLAVE_MISO_EN
   logic [WIDTH-1:0] tx, tx_next_word;
   logic [BC_W-1:0]  tx_cnt;
   logic [WC_W-1:0]  tx_word;

   // Word to load after the current one; zero once the bank is exhausted
   always_comb begin
      tx_next_word = '0;
      for (int k = 0; k < NUM_REGS; k++)
         if (tx_word == WC_W'(k))
            tx_next_word = data_in[k*WIDTH +: WIDTH];
   end

   // Transmit shifter: loads word 0 at frame start, advances on sclk fall
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx      <= '0;
         tx_cnt  <= '0;
         tx_word <= '0;
      end else if (start_frame) begin
         tx      <= data_in[0 +: WIDTH];
         tx_cnt  <= '0;
         tx_word <= WC_W'(1);
      end else if (state != IDLE && sclk_fall && !end_frame) begin
         if (tx_cnt == BC_W'(WIDTH - 1)) begin
            tx     <= tx_next_word;
            tx_cnt <= '0;
            if (tx_word != WC_W'(NUM_REGS))
               tx_word <= tx_word + 1'b1;
         end else begin
            tx_cnt <= tx_cnt + 1'b1;
            if (MSB_FIRST != 0) tx <= {tx[WIDTH-2:0], 1'b0};
            else                tx <= {1'b0, tx[WIDTH-1:1]};
         end
      end
   end

   assign master_miso = (state != IDLE) &
                        ((MSB_FIRST != 0) ? tx[WIDTH-1] : tx[0]);
`endif

endmodule
